// File: rtl/hls_deadlock_pkg.sv
// Shared constants and helpers for the HLS dataflow deadlock monitor.
// Info codes are two bits per channel: bit 0 = writer blocked on full, bit 1 = reader blocked on empty.
package hls_deadlock_pkg;

  localparam int DL_CNT_W = 16;

  localparam logic [1:0] BLK_NONE  = 2'b00;
  localparam logic [1:0] BLK_FULL  = 2'b01;
  localparam logic [1:0] BLK_EMPTY = 2'b10;
  localparam logic [1:0] BLK_BOTH  = 2'b11;

  function automatic logic [1:0] blk_code(input logic full, input logic empty);
    logic [1:0] code;
    code = BLK_NONE;
    if (full && empty) code = BLK_BOTH;
    else if (full)     code = BLK_FULL;
    else if (empty)   code = BLK_EMPTY;
    return code;
  endfunction

endpackage

// File: rtl/hls_deadlock_persist_cnt.sv
// Saturating persistence counter for one stream channel.
// The channel is confirmed only after THRESHOLD consecutive stalled cycles.
module hls_deadlock_persist_cnt
  import hls_deadlock_pkg::*;
#(
  parameter int THRESHOLD = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic raw,
  output logic conf
);

  localparam logic [DL_CNT_W-1:0] THR = DL_CNT_W'(THRESHOLD);

  logic [DL_CNT_W-1:0] cnt_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clear || !raw) begin
      cnt_reg <= '0;
    end else if (cnt_reg != THR) begin
      cnt_reg <= cnt_reg + {{(DL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign conf = (cnt_reg == THR);

endmodule

// File: rtl/hls_deadlock_axis_monitor.sv
// Deadlock monitor for an HLS dataflow region: filters per-channel stalls, aggregates child
// block flags, and reports a registered block flag with per-channel diagnostics.
module hls_deadlock_axis_monitor
  import hls_deadlock_pkg::*;
#(
  parameter int NUM_AXIS  = 2,
  parameter int NUM_SUB   = 1,
  parameter int THRESHOLD = 16,
  parameter int STICKY    = 0,
  parameter int IDX_W     = $clog2((NUM_AXIS > 2) ? NUM_AXIS : 2)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [NUM_AXIS-1:0]   axis_full_sigs,
  input  logic [NUM_AXIS-1:0]   axis_empty_sigs,
  input  logic [NUM_SUB-1:0]    sub_block_sigs,
  input  logic [NUM_SUB-1:0]    sub_idle_sigs,
  output logic [2*NUM_AXIS-1:0] axis_block_info,
  output logic [IDX_W-1:0]      first_block_idx,
  output logic                  first_block_valid,
  output logic                  block
);

  logic [NUM_AXIS-1:0]   conf;
  logic [2*NUM_AXIS-1:0] live_info;
  logic                  sub_all;
  logic                  det;
  logic [IDX_W-1:0]      low_idx;

  logic                  block_reg;
  logic [2*NUM_AXIS-1:0] info_reg;
  logic [IDX_W-1:0]      first_idx_reg;
  logic                  first_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_AXIS; gi = gi + 1) begin : g_ch
      hls_deadlock_persist_cnt #(
        .THRESHOLD(THRESHOLD)
      ) u_cnt (
        .clock(clock),
        .reset(reset),
        .clear(clear),
        .raw  (axis_full_sigs[gi] | axis_empty_sigs[gi]),
        .conf (conf[gi])
      );

      assign live_info[2*gi +: 2] = conf[gi] ? blk_code(axis_full_sigs[gi], axis_empty_sigs[gi])
                                             : BLK_NONE;
    end
  endgenerate

  // Children only count as deadlocked when none is still doing useful work.
  assign sub_all = (|sub_block_sigs) & (&(sub_block_sigs | sub_idle_sigs));
  assign det     = (|conf) | sub_all;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_AXIS - 1; i >= 0; i--) begin
      if (conf[i]) low_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      block_reg       <= 1'b0;
      info_reg        <= '0;
      first_idx_reg   <= '0;
      first_valid_reg <= 1'b0;
    end else if (clear) begin
      block_reg       <= 1'b0;
      info_reg        <= '0;
      first_idx_reg   <= '0;
      first_valid_reg <= 1'b0;
    end else begin
      if (STICKY == 0) begin
        block_reg <= det;
        info_reg  <= live_info;
      end else if (!block_reg && det) begin
        block_reg <= 1'b1;
        info_reg  <= live_info;
      end
      // Only a confirmed stream stall names a channel; child-only detections leave it unset.
      if (!first_valid_reg && (|conf)) begin
        first_idx_reg   <= low_idx;
        first_valid_reg <= 1'b1;
      end
    end
  end

  assign block             = block_reg;
  assign axis_block_info   = info_reg;
  assign first_block_idx   = first_idx_reg;
  assign first_block_valid = first_valid_reg;

endmodule

// File: tb/tb_hls_deadlock_axis_monitor.sv
// Bench for the deadlock monitor: a non-sticky 2-channel/3-child instance and a sticky 4-channel
// instance, checked against hand vectors and a run-length reference model.
module tb_hls_deadlock_axis_monitor;

  localparam int THR = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // instance 0: NUM_AXIS=2, NUM_SUB=3, non-sticky
  logic       clr0 = 1'b0;
  logic [1:0] full0 = '0, empty0 = '0;
  logic [2:0] sb0 = '0, si0 = '0;
  logic [3:0] info0;
  logic [0:0] idx0;
  logic       val0, blk0;

  // instance 1: NUM_AXIS=4, NUM_SUB=1, sticky
  logic       clr1 = 1'b0;
  logic [3:0] full1 = '0, empty1 = '0;
  logic [0:0] sb1 = '0, si1 = '0;
  logic [7:0] info1;
  logic [1:0] idx1;
  logic       val1, blk1;

  hls_deadlock_axis_monitor #(.NUM_AXIS(2), .NUM_SUB(3), .THRESHOLD(THR), .STICKY(0)) dut0 (
    .clock(clock), .reset(reset), .clear(clr0),
    .axis_full_sigs(full0), .axis_empty_sigs(empty0),
    .sub_block_sigs(sb0), .sub_idle_sigs(si0),
    .axis_block_info(info0), .first_block_idx(idx0),
    .first_block_valid(val0), .block(blk0)
  );

  hls_deadlock_axis_monitor #(.NUM_AXIS(4), .NUM_SUB(1), .THRESHOLD(THR), .STICKY(1)) dut1 (
    .clock(clock), .reset(reset), .clear(clr1),
    .axis_full_sigs(full1), .axis_empty_sigs(empty1),
    .sub_block_sigs(sb1), .sub_idle_sigs(si1),
    .axis_block_info(info1), .first_block_idx(idx1),
    .first_block_valid(val1), .block(blk1)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: consecutive-stall run lengths per channel, outputs derived from the rules.
  int         run [2][4];
  logic       mblk [2];
  logic [7:0] minfo [2];
  int         midx [2];
  logic       mval [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) run[d][i] = 0;
      mblk[d] = 1'b0; minfo[d] = '0; midx[d] = 0; mval[d] = 1'b0;
    end
  endtask

  task automatic model_edge(input int d, input int n, input bit sticky,
                            input logic [3:0] f, input logic [3:0] e,
                            input bit suball, input bit clr);
    bit         anyc;
    logic [7:0] live;
    int         low;
    anyc = 1'b0; live = '0; low = -1;
    for (int i = 0; i < n; i++) begin
      if (run[d][i] >= THR) begin
        anyc = 1'b1;
        live[2*i +: 2] = {e[i], f[i]};
        if (low < 0) low = i;
      end
    end
    if (clr) begin
      for (int i = 0; i < 4; i++) run[d][i] = 0;
      mblk[d] = 1'b0; minfo[d] = '0; midx[d] = 0; mval[d] = 1'b0;
    end else begin
      for (int i = 0; i < n; i++)
        run[d][i] = (f[i] | e[i]) ? ((run[d][i] < 100000) ? run[d][i] + 1 : run[d][i]) : 0;
      if (!sticky) begin
        mblk[d] = anyc | suball;
        minfo[d] = live;
      end else if (!mblk[d] && (anyc | suball)) begin
        mblk[d] = 1'b1;
        minfo[d] = live;
      end
      if (!mval[d] && anyc) begin
        midx[d] = low;
        mval[d] = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    chk("m0_block", 32'(blk0), 32'(mblk[0]));
    chk("m0_info",  32'(info0), 32'(minfo[0][3:0]));
    chk("m0_valid", 32'(val0), 32'(mval[0]));
    chk("m0_idx",   32'(idx0), 32'(midx[0]));
    chk("m1_block", 32'(blk1), 32'(mblk[1]));
    chk("m1_info",  32'(info1), 32'(minfo[1]));
    chk("m1_valid", 32'(val1), 32'(mval[1]));
    chk("m1_idx",   32'(idx1), 32'(midx[1]));
  endtask

  task automatic step();
    bit sa0, sa1;
    sa0 = (sb0 != 3'b000) && ((sb0 | si0) == 3'b111);
    sa1 = (sb1 != 1'b0);
    model_edge(0, 2, 1'b0, {2'b00, full0}, {2'b00, empty0}, sa0, clr0);
    model_edge(1, 4, 1'b1, full1, empty1, sa1, clr1);
    @(posedge clock);
    #1;
    check_model();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_blk0"}, 32'(blk0), 0);
    chk({tag, "_info0"}, 32'(info0), 0);
    chk({tag, "_val0"}, 32'(val0), 0);
    chk({tag, "_blk1"}, 32'(blk1), 0);
    chk({tag, "_info1"}, 32'(info1), 0);
    chk({tag, "_idx1"}, 32'(idx1), 0);
    chk({tag, "_val1"}, 32'(val1), 0);
  endtask

  typedef struct {
    logic [1:0] full;
    logic [1:0] empty;
    logic [2:0] sb;
    logic [2:0] si;
    logic       clr;
    logic       blk;
    logic [3:0] info;
    logic       idx;
    logic       vld;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int rep, input logic [1:0] f, input logic [1:0] e,
                     input logic [2:0] b, input logic [2:0] s, input logic c,
                     input logic xb, input logic [3:0] xi, input logic xx, input logic xv);
    vec_t v;
    v.full = f; v.empty = e; v.sb = b; v.si = s; v.clr = c;
    v.blk = xb; v.info = xi; v.idx = xx; v.vld = xv;
    for (int r = 0; r < rep; r++) vecs.push_back(v);
  endtask

  initial begin
    // Short full[1] burst never confirms.
    add(3, 2'b10, 2'b00, 3'b000, 3'b000, 0, 0, 4'b0000, 0, 0);
    add(2, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 4'b0000, 0, 0);
    // empty[0] held 10 cycles, block from edge 5, then drops two edges after release.
    add(4, 2'b00, 2'b01, 3'b000, 3'b000, 0, 0, 4'b0000, 0, 0);
    add(6, 2'b00, 2'b01, 3'b000, 3'b000, 0, 1, 4'b0010, 0, 1);
    add(1, 2'b00, 2'b00, 3'b000, 3'b000, 0, 1, 4'b0000, 0, 1);
    add(1, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 4'b0000, 0, 1);
    add(1, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0, 4'b0000, 0, 0);
    // Child aggregate path: one cycle, no channel index.
    add(1, 2'b00, 2'b00, 3'b101, 3'b010, 0, 1, 4'b0000, 0, 0);
    add(1, 2'b00, 2'b00, 3'b101, 3'b000, 0, 0, 4'b0000, 0, 0);
    add(1, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 4'b0000, 0, 0);
    // clear on the would-be confirming edge restarts the count.
    add(3, 2'b01, 2'b00, 3'b000, 3'b000, 0, 0, 4'b0000, 0, 0);
    add(1, 2'b01, 2'b00, 3'b000, 3'b000, 1, 0, 4'b0000, 0, 0);
    add(4, 2'b01, 2'b00, 3'b000, 3'b000, 0, 0, 4'b0000, 0, 0);
    add(1, 2'b01, 2'b00, 3'b000, 3'b000, 0, 1, 4'b0001, 0, 1);
    add(1, 2'b00, 2'b00, 3'b000, 3'b000, 0, 1, 4'b0000, 0, 1);
    add(1, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 4'b0000, 0, 1);
    // Both channels confirm together: lowest index wins.
    add(4, 2'b11, 2'b00, 3'b000, 3'b000, 0, 0, 4'b0000, 0, 1);
    add(1, 2'b11, 2'b00, 3'b000, 3'b000, 0, 1, 4'b0101, 0, 1);
    add(1, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0, 4'b0000, 0, 0);
    add(4, 2'b10, 2'b10, 3'b000, 3'b000, 0, 0, 4'b0000, 0, 0);
    add(2, 2'b10, 2'b10, 3'b000, 3'b000, 0, 1, 4'b1100, 1, 1);
    add(1, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0, 4'b0000, 0, 0);

    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk_all_zero("reset");
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_model();

    // Table-driven vectors on the non-sticky instance.
    for (int k = 0; k < vecs.size(); k++) begin
      full0 = vecs[k].full; empty0 = vecs[k].empty;
      sb0 = vecs[k].sb; si0 = vecs[k].si; clr0 = vecs[k].clr;
      step();
      chk($sformatf("vec%0d_block", k), 32'(blk0), 32'(vecs[k].blk));
      chk($sformatf("vec%0d_info", k), 32'(info0), 32'(vecs[k].info));
      chk($sformatf("vec%0d_idx", k), 32'(idx0), 32'(vecs[k].idx));
      chk($sformatf("vec%0d_valid", k), 32'(val0), 32'(vecs[k].vld));
      $display("vec %0d: full=%b empty=%b sb=%b si=%b clr=%b -> block=%b info=%b idx=%0d valid=%b",
               k, vecs[k].full, vecs[k].empty, vecs[k].sb, vecs[k].si, vecs[k].clr,
               blk0, info0, idx0, val0);
    end
    clr0 = 1'b0; full0 = '0; empty0 = '0; sb0 = '0; si0 = '0;

    // Sticky: channels 2 and 3 confirm together, latch holds after release, clear empties it.
    full1 = 4'b1100;
    repeat (4) step();
    chk("stk_pre_block", 32'(blk1), 0);
    step();
    chk("stk_block", 32'(blk1), 1);
    chk("stk_info", 32'(info1), 32'h50);
    chk("stk_idx", 32'(idx1), 2);
    chk("stk_valid", 32'(val1), 1);
    full1 = 4'b0000;
    repeat (3) step();
    chk("stk_hold_block", 32'(blk1), 1);
    chk("stk_hold_info", 32'(info1), 32'h50);
    clr1 = 1'b1;
    step();
    clr1 = 1'b0;
    chk("stk_clr_block", 32'(blk1), 0);
    chk("stk_clr_info", 32'(info1), 0);
    chk("stk_clr_valid", 32'(val1), 0);
    $display("sticky sequence: block=%b info=%h idx=%0d valid=%b", blk1, info1, idx1, val1);

    // Sticky info stays frozen while live codes change.
    empty1 = 4'b0001;
    repeat (5) step();
    full1 = 4'b0001;
    step();
    chk("stk_frozen_info", 32'(info1), 32'h02);

    // Async reset mid-count (instance 0) and in sticky hold (instance 1).
    full0 = 2'b01;
    repeat (2) step();
    chk("pre_rst_hold", 32'(blk1), 1);
    #3 reset = 1'b1;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    #1 reset = 1'b0;
    repeat (4) step();
    chk("rst_recount_blk0", 32'(blk0), 0);
    chk("rst_recount_blk1", 32'(blk1), 0);
    step();
    chk("rst_confirm_blk0", 32'(blk0), 1);
    chk("rst_confirm_blk1", 32'(blk1), 1);
    $display("reset sequence: blk0=%b blk1=%b info1=%h", blk0, blk1, info1);
    clr0 = 1'b1; clr1 = 1'b1;
    full0 = '0; empty0 = '0; full1 = '0; empty1 = '0;
    step();
    clr0 = 1'b0; clr1 = 1'b0;

    // Randomised stimulus with long stall runs against the reference model.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 5) == 0) full0[i] = ~full0[i];
        if ($urandom_range(0, 5) == 0) empty0[i] = ~empty0[i];
      end
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 5) == 0) full1[i] = ~full1[i];
        if ($urandom_range(0, 5) == 0) empty1[i] = ~empty1[i];
      end
      if ($urandom_range(0, 7) == 0) begin
        sb0 = 3'($urandom_range(0, 7));
        si0 = 3'($urandom_range(0, 7));
        sb1 = 1'($urandom_range(0, 1));
        si1 = 1'($urandom_range(0, 1));
      end
      clr0 = ($urandom_range(0, 39) == 0);
      clr1 = ($urandom_range(0, 29) == 0);
      step();
      $display("rnd %0d: blk0=%b info0=%b val0=%b blk1=%b info1=%h idx1=%0d val1=%b",
               c, blk0, info0, val0, blk1, info1, idx1, val1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
